// File: rtl/i2c_byte_sequencer.sv
// Single-byte I2C master: START, address+R/W, one data byte, STOP on open-drain
// SCL/SDA enables, driven by a four-quarter bit slot with SCL stretch support.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready=1
// START | START slot: SDA falls while SCL is released
// ADDR  | 8 slots shifting out {addr, rw}, MSB first
// AACK  | slave address acknowledge slot
// DATA  | 8 slots: write byte out or read byte in, MSB first
// DACK  | slave ACK on write, master NACK on read
// STOP  | STOP slot: SDA rises while SCL is released
// DONE  | one-cycle response pulse
module i2c_byte_sequencer #(
  parameter int unsigned DIVIDER     = 250,
  parameter int unsigned STRETCH_MAX = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       rsp_timeout,
  output logic       busy,
  output logic       scl_oe,
  input  logic       scl_in,
  output logic       sda_oe,
  input  logic       sda_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP, S_DONE
  } state_t;

  localparam int QW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int SW = $clog2(STRETCH_MAX + 1);
  localparam logic [QW-1:0] Q_LOAD = QW'(DIVIDER - 1);
  localparam logic [SW-1:0] S_LAST = SW'(STRETCH_MAX - 1);

  state_t         state_q;
  state_t         state_d;
  logic [1:0]     quarter_q;
  logic [QW-1:0]  q_cnt_q;
  logic [2:0]     bit_cnt_q;
  logic [SW-1:0]  stretch_q;
  logic [6:0]     addr_q;
  logic           rw_q;
  logic [7:0]     wdata_q;
  logic           sda_hold_q;

  logic           active;
  logic           accept;
  logic           stall;
  logic           q_tc;
  logic           slot_end;
  logic           sample;
  logic           timeout_hit;
  logic [7:0]     addr_byte;
  logic           tx_bit;
  logic           sda_bit;

  assign active      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign accept      = cmd_valid && cmd_ready;
  assign stall       = active && (quarter_q == 2'd2) && !scl_in;
  assign q_tc        = active && !stall && (q_cnt_q == '0);
  assign slot_end    = q_tc && (quarter_q == 2'd3);
  assign sample      = q_tc && (quarter_q == 2'd2);
  assign timeout_hit = stall && (stretch_q == S_LAST);
  assign addr_byte   = {addr_q, rw_q};
  assign tx_bit      = (state_q == S_ADDR) ? addr_byte[bit_cnt_q] : wdata_q[bit_cnt_q];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a stretch timeout overrides the normal slot sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_START;
      S_START: if (slot_end) state_d = S_ADDR;
      S_ADDR:  if (slot_end && (bit_cnt_q == 3'd0)) state_d = S_AACK;
      S_AACK:  if (slot_end) state_d = rsp_nack ? S_STOP : S_DATA;
      S_DATA:  if (slot_end && (bit_cnt_q == 3'd0)) state_d = S_DACK;
      S_DACK:  if (slot_end) state_d = S_STOP;
      S_STOP:  if (slot_end) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A STOP that itself times out finishes rather than restarting STOP forever
    if (timeout_hit) begin
      state_d = (state_q == S_STOP) ? S_DONE : S_STOP;
    end
  end

  // Output logic
  always_comb begin
    sda_bit = 1'b0;
    case (state_q)
      S_ADDR:  sda_bit = !tx_bit;
      S_DATA:  sda_bit = !rw_q && !tx_bit;
      default: sda_bit = 1'b0;
    endcase
  end

  always_comb begin
    scl_oe    = 1'b0;
    sda_oe    = 1'b0;
    case (state_q)
      S_START: sda_oe = quarter_q[1];
      S_ADDR, S_AACK, S_DATA, S_DACK: begin
        scl_oe = !quarter_q[1];
        // Q0 keeps the previous slot's SDA; the new bit appears at Q1 entry
        sda_oe = (quarter_q == 2'd0) ? sda_hold_q : sda_bit;
      end
      S_STOP: begin
        scl_oe = !quarter_q[1];
        sda_oe = (quarter_q != 2'd3);
      end
      default: begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
      end
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_DONE);

  // Slot timing, command capture and response fields
  always_ff @(posedge clk) begin
    if (rst) begin
      quarter_q   <= 2'd0;
      q_cnt_q     <= '0;
      bit_cnt_q   <= 3'd7;
      stretch_q   <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      sda_hold_q  <= 1'b0;
      rsp_rdata   <= '0;
      rsp_nack    <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (accept) begin
        addr_q      <= cmd_addr;
        rw_q        <= cmd_rw;
        wdata_q     <= cmd_wdata;
        rsp_rdata   <= '0;
        rsp_nack    <= 1'b0;
        rsp_timeout <= 1'b0;
      end

      if (state_d != state_q) begin
        quarter_q <= 2'd0;
        q_cnt_q   <= Q_LOAD;
        bit_cnt_q <= 3'd7;
      end else if (q_tc) begin
        q_cnt_q   <= Q_LOAD;
        quarter_q <= quarter_q + 2'd1;
        if (slot_end) bit_cnt_q <= bit_cnt_q - 3'd1;
      end else if (active && !stall) begin
        q_cnt_q <= q_cnt_q - QW'(1);
      end

      if (slot_end) sda_hold_q <= sda_oe;

      if ((state_d != state_q) || !active || scl_in || (q_tc && (quarter_q == 2'd1))) begin
        stretch_q <= '0;
      end else if (stall) begin
        stretch_q <= stretch_q + SW'(1);
      end

      if (sample) begin
        case (state_q)
          S_AACK:  if (sda_in) rsp_nack <= 1'b1;
          S_DACK:  if (!rw_q && sda_in) rsp_nack <= 1'b1;
          S_DATA:  if (rw_q) rsp_rdata[bit_cnt_q] <= sda_in;
          default: ;
        endcase
      end

      if (timeout_hit) begin
        rsp_timeout <= 1'b1;
        rsp_rdata   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// Bench for i2c_byte_sequencer: a bus-level slave model observes SCL/SDA edges,
// vector table plus random commands are checked against protocol-level expectations.
module tb_i2c_byte_sequencer;
  localparam int D        = 4;
  localparam int HOLD_LEN = 37;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = '0;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       rsp_timeout;
  logic       busy;
  logic       scl_oe;
  logic       scl_in;
  logic       sda_oe;
  logic       sda_in;
  logic       scl_hold = 1'b0;
  logic       s_sda_low = 1'b0;

  assign scl_in = !(scl_oe || scl_hold);
  assign sda_in = !(sda_oe || s_sda_low);

  i2c_byte_sequencer #(.DIVIDER(D)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .scl_oe(scl_oe), .scl_in(scl_in), .sda_oe(sda_oe), .sda_in(sda_in)
  );

  // Second instance with a short stretch limit; its SCL is held low forever
  logic       cmd_valid_t = 1'b0;
  logic       cmd_ready_t;
  logic       rsp_valid_t;
  logic [7:0] rsp_rdata_t;
  logic       rsp_nack_t;
  logic       rsp_timeout_t;
  logic       busy_t;
  logic       scl_oe_t;
  logic       scl_in_t;
  logic       sda_oe_t;
  logic       sda_in_t;
  assign scl_in_t = 1'b0;
  assign sda_in_t = !sda_oe_t;

  i2c_byte_sequencer #(.DIVIDER(D), .STRETCH_MAX(10)) dut_to (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid_t), .cmd_ready(cmd_ready_t),
    .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_t), .rsp_rdata(rsp_rdata_t), .rsp_nack(rsp_nack_t),
    .rsp_timeout(rsp_timeout_t), .busy(busy_t),
    .scl_oe(scl_oe_t), .scl_in(scl_in_t), .sda_oe(sda_oe_t), .sda_in(sda_in_t)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Bus-level slave: START resets the bit count, rising SCL captures SDA,
  // falling SCL sets up the next bit (ACK, read data), optional stretch of bit 4.
  logic       ack_a = 1'b1, ack_d = 1'b1;
  logic [7:0] sdat = '0;
  logic       stretch_req = 1'b0;
  int         nbits = 0;
  logic [7:0] abyte = '0, dbyte = '0;
  logic       mack = 1'b0;
  int         hold_cnt = 0;
  logic       hold_sda = 1'b0;
  logic       sda_moved = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       scl_l, sda_l;

  always @(negedge clk) begin
    scl_l = scl_in;
    sda_l = sda_in;
    if (prev_scl && scl_l && prev_sda && !sda_l) begin
      nbits = 0;
      s_sda_low = 1'b0;
    end else if (!prev_scl && scl_l) begin
      nbits++;
      if (nbits <= 8) abyte = {abyte[6:0], sda_l};
      else if (nbits >= 10 && nbits <= 17) dbyte = {dbyte[6:0], sda_l};
      else if (nbits == 18) mack = sda_l;
    end else if (prev_scl && !scl_l) begin
      s_sda_low = 1'b0;
      if (nbits + 1 == 9) s_sda_low = ack_a;
      else if (nbits + 1 >= 10 && nbits + 1 <= 17) s_sda_low = ack_a && abyte[0] && !sdat[16 - nbits];
      else if (nbits + 1 == 18) s_sda_low = ack_a && !abyte[0] && ack_d;
    end
    if (scl_hold) begin
      if (!scl_oe) begin
        if (hold_cnt == 0) hold_sda = sda_oe;
        else if (sda_oe != hold_sda) sda_moved = 1'b1;
        if (hold_cnt == HOLD_LEN) begin
          scl_hold = 1'b0;
          stretch_req = 1'b0;
        end else begin
          hold_cnt++;
        end
      end
    end else if (stretch_req && nbits == 3 && scl_oe) begin
      scl_hold = 1'b1;
      hold_cnt = 0;
    end
    prev_scl = scl_l;
    prev_sda = sda_l;
  end

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk({name, " ready_wait"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_txn(input string name, input logic [6:0] a, input logic rw,
                         input logic [7:0] wd, input logic aa, input logic ad,
                         input logic [7:0] sd, input logic st, input int exp_lat,
                         input logic exp_nack, input logic [7:0] exp_rd);
    int cyc;
    ack_a = aa; ack_d = ad; sdat = sd; stretch_req = st; sda_moved = 1'b0;
    wait_ready(name);
    cmd_addr = a; cmd_rw = rw; cmd_wdata = wd; cmd_valid = 1'b1;
    @(negedge clk);
    cyc = 1;
    cmd_valid = 1'b0;
    chk({name, " busy_after_accept"}, 32'({busy, cmd_ready}), 32'b10);
    while (!rsp_valid && cyc < 3000) begin
      // Commands offered while busy must not disturb the transfer
      if (cyc >= 2 && cyc < 40) begin
        cmd_valid = 1'b1;
        cmd_addr  = 7'($urandom);
        cmd_rw    = 1'($urandom);
        cmd_wdata = 8'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk({name, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({name, " rsp_nack"}, 32'(rsp_nack), 32'(exp_nack));
    chk({name, " rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
    chk({name, " rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    chk({name, " done_ready_busy"}, 32'({cmd_ready, busy}), 32'b01);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({name, " idle_after_done"}, 32'({rsp_valid, busy, cmd_ready}), 32'b001);
    chk({name, " nack_held"}, 32'(rsp_nack), 32'(exp_nack));
    chk({name, " addr_byte"}, 32'(abyte), 32'({a, rw}));
    chk({name, " scl_pulses"}, 32'(nbits), aa ? 32'd19 : 32'd10);
    if (aa && !rw) chk({name, " data_byte"}, 32'(dbyte), 32'(wd));
    if (aa && rw) chk({name, " master_nack"}, 32'(mack), 32'd1);
    if (st) chk({name, " sda_during_stretch"}, 32'(sda_moved), 32'd0);
  endtask

  typedef struct {
    logic [6:0] a;
    logic       rw;
    logic [7:0] wd;
    logic       aa;
    logic       ad;
    logic [7:0] sd;
    logic       st;
    int         lat;
    logic       nack;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [6:0] ra;
    logic rrw, raa, rad, rst_req;
    logic [7:0] rwd, rsd;
    int elat;
    logic enack;
    logic [7:0] erd;

    vecs[0] = '{7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 321, 1'b0, 8'h00};
    vecs[1] = '{7'h3C, 1'b1, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b0, 321, 1'b0, 8'h5A};
    vecs[2] = '{7'h50, 1'b0, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0, 177, 1'b1, 8'h00};
    vecs[3] = '{7'h3C, 1'b1, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0, 177, 1'b1, 8'h00};
    vecs[4] = '{7'h12, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 321, 1'b1, 8'h00};
    vecs[5] = '{7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b1, 358, 1'b0, 8'h00};
    vecs[6] = '{7'h7F, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 321, 1'b0, 8'h00};
    vecs[7] = '{7'h00, 1'b1, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 321, 1'b0, 8'hFF};

    repeat (3) @(negedge clk);
    chk("reset cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset enables", 32'({scl_oe, sda_oe}), 32'd0);
    chk("reset busy_valid", 32'({busy, rsp_valid}), 32'd0);
    chk("reset rsp_fields", 32'({rsp_rdata, rsp_nack, rsp_timeout}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset release cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].rw, vecs[i].wd, vecs[i].aa,
              vecs[i].ad, vecs[i].sd, vecs[i].st, vecs[i].lat, vecs[i].nack, vecs[i].rd);
    end

    // Random commands against a transaction-level model
    for (int i = 0; i < 12; i++) begin
      ra  = 7'($urandom);
      rrw = 1'($urandom);
      rwd = 8'($urandom);
      raa = ($urandom_range(0, 3) != 0);
      rad = ($urandom_range(0, 3) != 0);
      rsd = 8'($urandom);
      rst_req = ($urandom_range(0, 3) == 0);
      elat  = (raa ? 20 * 4 * D : 11 * 4 * D) + 1 + (rst_req ? HOLD_LEN : 0);
      enack = !raa || (!rrw && !rad);
      erd   = (raa && rrw) ? rsd : 8'h00;
      run_txn($sformatf("rnd%0d", i), ra, rrw, rwd, raa, rad, rsd, rst_req, elat, enack, erd);
    end

    // Reset in the middle of the data byte
    ack_a = 1'b1; ack_d = 1'b1; stretch_req = 1'b0;
    wait_ready("midrst");
    cmd_addr = 7'h2A; cmd_rw = 1'b0; cmd_wdata = 8'hC3; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (nbits != 11 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("midrst reached data", 32'(nbits), 32'd11);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst enables", 32'({scl_oe, sda_oe}), 32'd0);
    chk("midrst busy_ready", 32'({busy, cmd_ready}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst cmd_ready", 32'(cmd_ready), 32'd1);
    run_txn("post_rst", 7'h2A, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00, 1'b0, 321, 1'b0, 8'h00);

    // Stretch timeout on the short-limit instance
    cmd_addr = 7'h44; cmd_rw = 1'b1;
    @(negedge clk);
    chk("to ready", 32'(cmd_ready_t), 32'd1);
    cmd_valid_t = 1'b1;
    @(negedge clk);
    cmd_valid_t = 1'b0;
    n = 1;
    while (!rsp_valid_t && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("to rsp_valid", 32'(rsp_valid_t), 32'd1);
    chk("to rsp_timeout", 32'(rsp_timeout_t), 32'd1);
    chk("to rsp_nack", 32'(rsp_nack_t), 32'd0);
    chk("to rsp_rdata", 32'(rsp_rdata_t), 32'd0);
    @(negedge clk);
    chk("to back idle", 32'({busy_t, cmd_ready_t}), 32'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_byte_sequencer.md
# i2c_byte_sequencer

Single-byte I2C master transaction sequencer. It accepts one command (7-bit address, R/W, write data) over a valid/ready handshake. It generates START, address byte, data byte and STOP on open-drain SCL/SDA enables, using a four-quarter bit slot with SCL clock-stretch hold. It sits between register-level host logic and the board I2C pads, replacing free-running SCL generation with command-driven sequencing.

## Interface
- DIVIDER, default 250: clk cycles per quarter bit slot; bit slot = 4*DIVIDER cycles without stretching; legal ≥ 2.
- STRETCH_MAX, default 65535: maximum clk cycles SCL may be held low by a slave in one Q2 before abort.
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_addr  input  7  target address.
- cmd_rw  input  1  1 = read, 0 = write.
- cmd_wdata  input  8  write byte; ignored on read.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  8  read byte; 0 on write, NACK or timeout.
- rsp_nack  output  1  address or write-data NACK seen; qualified by rsp_valid.
- rsp_timeout  output  1  stretch limit exceeded; qualified by rsp_valid.
- busy  output  1  transaction in progress (not IDLE).
- scl_oe  output  1  1 = pull SCL low.
- scl_in  input  1  sampled SCL pad level.
- sda_oe  output  1  1 = pull SDA low.
- sda_in  input  1  sampled SDA pad level.

## Operation
- States: IDLE, START, ADDR, AACK, DATA, DACK, STOP, DONE.
- Transitions:
  - IDLE→START on cmd_valid && cmd_ready. Command fields are latched on that edge.
  - START→ADDR after 1 slot.
  - ADDR→AACK after 8 slots.
  - AACK→DATA if ACK; AACK→STOP if NACK.
  - DATA→DACK after 8 slots.
  - DACK→STOP.
  - STOP→DONE after 1 slot.
  - DONE→IDLE after 1 cycle.
- Quarters within a slot, Q0..Q3, each DIVIDER cycles:
  - Normal bit: Q0/Q1 scl_oe=1, Q2/Q3 scl_oe=0. SDA value updates at entry to Q1 and is held through Q3.
  - START slot: scl_oe=0 throughout. sda_oe=0 in Q0/Q1, sda_oe=1 in Q2/Q3.
  - STOP slot: scl_oe=1 in Q0/Q1, scl_oe=0 in Q2/Q3. sda_oe=1 in Q0–Q2, sda_oe=0 in Q3.
- ADDR shifts out {cmd_addr, cmd_rw}, MSB first; sda_oe = ~bit.
- AACK: sda_oe=0; ACK when sampled sda_in=0.
- DATA, write: shifts out cmd_wdata MSB first.
- DATA, read: sda_oe=0; samples into rsp_rdata MSB first.
- DACK, write: sda_oe=0; slave ACK sampled, NACK sets rsp_nack.
- DACK, read: master NACK (sda_oe=0), since the transfer is a single byte.
- Sampling: sda_in is sampled on the clk edge where the quarter counter leaves Q2 for Q3.
- Stretch: in Q2 of any slot, while scl_in=0 the quarter counter holds and a stretch counter increments. The stretch counter clears when scl_in=1 or at Q2 entry.
- Timeout: a stretch count reaching STRETCH_MAX forces STOP immediately and sets rsp_timeout. rsp_nack stays 0 unless a NACK was already seen.
- Response: in DONE, rsp_valid=1 with rsp_rdata/rsp_nack/rsp_timeout stable. The fields hold until the next command is accepted.

## Timing
- Reset values: cmd_ready=0 while rst=1; cmd_ready=1 the first cycle after rst deasserts.
- Reset values, all other outputs: scl_oe=0, sda_oe=0, rsp_valid=0, rsp_rdata=0, rsp_nack=0, rsp_timeout=0, busy=0.
- cmd_ready=1 only in IDLE. busy=1 from the cycle after acceptance through DONE.
- The START slot Q0 begins the cycle after acceptance.
- Latency without stretch, acceptance edge to rsp_valid:
  - Full transaction (20 slots): 80*DIVIDER+1 cycles.
  - Address NACK (11 slots): 44*DIVIDER+1 cycles.
- Stretching adds exactly the held cycles.
- cmd_valid while busy is ignored; there is no queuing.
- cmd_valid in the DONE cycle is not accepted; it is accepted at the earliest in the following IDLE cycle.
- Reset mid-transaction: on the next edge all enables release and the state goes to IDLE. No STOP is emitted.
- scl_in/sda_in are assumed synchronized externally; no internal synchronizer.

## Test plan
- DIVIDER=4, write addr 0x50 data 0xA5, slave ACKs both:
  - SDA bits 1010000,0 then 10100101.
  - rsp_valid at cycle 321 after acceptance, with rsp_nack=0 and rsp_rdata=0x00.
- DIVIDER=4, read addr 0x3C, slave ACKs and drives 0x5A:
  - rsp_rdata=0x5A; master NACK in DACK (sda_oe=0); rsp_nack=0.
- Address NACK (sda_in=1 in AACK):
  - DATA is skipped and STOP follows.
  - rsp_valid at cycle 177 with rsp_nack=1.
- Slave holds scl_in=0 for 37 cycles in Q2 of ADDR bit 3:
  - Counter frozen; rsp_valid at cycle 358; SDA unchanged while held.
- STRETCH_MAX=10, scl_in held low indefinitely:
  - Abort via STOP; rsp_timeout=1 and rsp_nack=0; back in IDLE with cmd_ready=1.
- rst asserted during DATA bit 2:
  - Next cycle scl_oe=0, sda_oe=0, busy=0, cmd_ready=0.
  - After rst deasserts: cmd_ready=1, and a new command completes normally.
